// File: rtl/router_port_arbiter.sv
`default_nettype none
// ============================================================================
// router_port_arbiter : per-output wormhole round-robin arbiter with watchdog
// Revision: 1.0
// ============================================================================
module router_port_arbiter #(
    parameter int N_PORTS   = 5,
    parameter int MAX_BEATS = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_PORTS-1:0]         req_i,
    input  logic [N_PORTS-1:0]         last_i,
    input  logic                       out_tready_i,
    output logic [N_PORTS-1:0]         grant_o,
    output logic [$clog2(N_PORTS)-1:0] grant_idx_o,
    output logic                       locked_o,
    output logic                       pkt_done_o,
    output logic                       timeout_o
);

    localparam int C_IDX_W  = $clog2(N_PORTS);
    localparam int C_BEAT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state;
    logic [N_PORTS-1:0]   r_grant;
    logic [N_PORTS-1:0]   w_grant;
    logic [C_IDX_W-1:0]   r_grant_idx;
    logic [C_IDX_W-1:0]   w_grant_idx;
    logic [C_IDX_W-1:0]   r_ptr;
    logic [C_IDX_W-1:0]   w_ptr;
    logic [C_BEAT_W-1:0]  r_beats;
    logic [C_BEAT_W-1:0]  w_beats;
    logic [C_BEAT_W-1:0]  w_beats_inc;
    logic                 r_pkt_done;
    logic                 w_pkt_done;
    logic                 r_timeout;
    logic                 w_timeout;
    logic [C_IDX_W-1:0]   w_sel_idx;
    logic                 w_xfer;
    logic                 w_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= C_IDX_W'(N_PORTS - 1);
            r_beats     <= '0;
            r_pkt_done  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_grant     <= w_grant;
            r_grant_idx <= w_grant_idx;
            r_ptr       <= w_ptr;
            r_beats     <= w_beats;
            r_pkt_done  <= w_pkt_done;
            r_timeout   <= w_timeout;
        end
    end

    always_comb begin
        // Scan farthest-to-nearest from ptr so the nearest requester is written last and wins.
        w_sel_idx = r_ptr;
        for (int i = N_PORTS; i >= 1; i--) begin
            int j;
            j = int'(r_ptr) + i;
            if (j >= N_PORTS) begin
                j = j - N_PORTS;
            end
            if (req_i[j]) begin
                w_sel_idx = C_IDX_W'(j);
            end
        end

        w_xfer      = req_i[r_grant_idx] & out_tready_i;
        w_last      = last_i[r_grant_idx];
        w_beats_inc = r_beats + C_BEAT_W'(1);

        w_state     = r_state;
        w_grant     = r_grant;
        w_grant_idx = r_grant_idx;
        w_ptr       = r_ptr;
        w_beats     = r_beats;
        w_pkt_done  = 1'b0;
        w_timeout   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|req_i) begin
                    w_state              = S_LOCKED;
                    w_grant              = '0;
                    w_grant[w_sel_idx]   = 1'b1;
                    w_grant_idx          = w_sel_idx;
                end
            end
            S_LOCKED: begin
                if (w_xfer) begin
                    w_beats = w_beats_inc;
                    // A real TLAST takes precedence over the watchdog on the same beat.
                    if (w_last || (w_beats_inc == C_BEAT_W'(MAX_BEATS))) begin
                        w_pkt_done = w_last;
                        w_timeout  = ~w_last;
                        w_state    = S_IDLE;
                        w_grant    = '0;
                        w_ptr      = r_grant_idx;
                        w_beats    = '0;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_grant = '0;
            end
        endcase
    end

    assign grant_o     = r_grant;
    assign grant_idx_o = r_grant_idx;
    assign locked_o    = (r_state == S_LOCKED);
    assign pkt_done_o  = r_pkt_done;
    assign timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Per-output-port wormhole arbiter for the 5-port XY mesh router.
- One instance sits in front of each router output port's AXI-Stream mux. It chooses which input port, among those whose head flit routes to this output, owns the output.
- Ownership is held for a whole packet, from the first beat through the TLAST beat, so flits of different packets never interleave.
- Priority is round-robin. A beat watchdog forces release if a packet never terminates.

Parameters:
- N_PORTS, 5, number of competing input ports (local plus N/E/S/W).
- MAX_BEATS, 256, maximum beats per packet before the watchdog fires; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  N_PORTS  per-input TVALID, already qualified by the route-compute result for this output.
- last_i  in  N_PORTS  per-input TLAST.
- out_tready_i  in  1  TREADY of the downstream output channel.
- grant_o  out  N_PORTS  one-hot mux select and TREADY steering; all zeros when unlocked.
- grant_idx_o  out  $clog2(N_PORTS)  binary index of the current grantee; holds its last value when unlocked.
- locked_o  out  1  a packet currently owns the output.
- pkt_done_o  out  1  one-cycle pulse on the TLAST handshake.
- timeout_o  out  1  one-cycle pulse when the watchdog forces release.

Behaviour:
- Reset (rst_i high at a clock edge) drives every output to zero:
  - grant_o=0, grant_idx_o=0, locked_o=0, pkt_done_o=0, timeout_o=0.
  - Round-robin pointer ptr=N_PORTS-1, so port 0 has highest priority after reset.
  - Beat counter beats=0; state=IDLE.
  - Reset taken mid-packet drops the lock immediately. Upstream is responsible for flushing.
- State IDLE:
  - If req_i is non-zero, select the first set bit searching ptr+1, ptr+2, … modulo N_PORTS.
  - Register grant_o/grant_idx_o, set locked_o=1, go to LOCKED.
  - Arbitration latency is exactly 1 cycle from request to grant.
  - If req_i is zero, stay in IDLE with grant_o=0.
- State LOCKED, grantee g:
  - A beat transfers when req_i[g] & out_tready_i.
  - Each transfer increments beats (width $clog2(MAX_BEATS+1), saturating is not needed because release happens first).
  - req_i[g]=0 mid-packet holds the lock: wormhole semantics, no re-arbitration, beats unchanged.
  - Requests from other ports are ignored while locked.
  - Transfer with last_i[g]=1: next cycle pulse pkt_done_o, clear grant_o and locked_o, set ptr<=g, beats<=0, go to IDLE.
  - Watchdog: a transfer with last_i[g]=0 that brings beats to MAX_BEATS has the same effect as a last beat, except it pulses timeout_o instead of pkt_done_o and the packet counts as released.
  - If a transfer is both the last beat and the MAX_BEATS-th beat, only pkt_done_o fires.
- Turnaround:
  - Release always returns through IDLE, giving a 1-cycle bubble between packets.
  - The maximum sustained throughput of a single-beat-packet stream is therefore 1 beat per 2 cycles per output. This is accepted.
- Fairness:
  - Any port continuously requesting is granted within N_PORTS-1 packets of other ports.
- Invariants:
  - grant_o is one-hot or zero.
  - grant_o non-zero if and only if locked_o=1.
  - grant_idx_o equals the index of the set grant_o bit when locked.
  - pkt_done_o and timeout_o never assert together.

Test Plan:
1. Reset, then req_i=5'b00001 held with single-beat packets (last_i=1, out_tready_i=1) → grant_o=00001 one cycle after the request, pkt_done_o pulses one cycle after the handshake, and the next grant follows the idle bubble.
2. req_i=5'b11111 continuously, all packets 2 beats → grant order 0,1,2,3,4,0 with grant_idx_o matching; exactly 5 pkt_done_o pulses in the first 5 packets.
3. Port 2 granted on a 4-beat packet, req_i[2] dropped for 3 cycles after beat 1 while req_i[4]=1 → grant_o stays 00100, beats resume at 2, and port 4 is granted only after port 2's TLAST.
4. out_tready_i=0 for 10 cycles mid-packet → no beat counted, lock held; when out_tready_i returns, the remaining beats complete and pkt_done_o pulses once.
5. MAX_BEATS=8, port 1 streams without last_i → timeout_o pulses one cycle after the 8th handshake, grant released, ptr=1, so a waiting port 3 wins next over port 0.
6. rst_i asserted during beat 3 of a locked packet → all outputs 0 on the following cycle; after rst_i deasserts, req_i=5'b10001 grants port 0.
